// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: splits cache line reads/write-backs into BURST_BITS memory beats; define LINE_ADAPTOR_TIMEOUT_EN to abort stalled bursts
module line_burst_adaptor #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [LINE_BITS-1:0]  line_i,
  output logic [LINE_BITS-1:0]  line_o,
  output logic                  resp_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic [BURST_BITS-1:0] burst_i,
  output logic [BURST_BITS-1:0] burst_o,
  input  logic                  resp_i,
  output logic                  timeout_o
);
  localparam int BEATS = LINE_BITS / BURST_BITS;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [KW-1:0] beat;
  logic [LINE_BITS-1:0] wr_line;
  logic busy, last, stall, accept;
  assign busy = state == READ || state == WRITE;
  assign last = resp_i && beat == KW'(BEATS - 1);
  assign accept = state == IDLE && (read_i || write_i);
  assign burst_o = state == WRITE ? wr_line[beat*BURST_BITS +: BURST_BITS] : '0;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign stall = !resp_i && wait_cnt == 8'd254;
  assign timeout_o = state == DONE && wait_cnt == 8'hff;
  // consecutive unacknowledged burst cycles; held at 255 through DONE to flag the abort
  always_ff @(posedge clk or negedge rst)
    if (!rst) wait_cnt <= '0;
    else if (state == IDLE) wait_cnt <= '0;
    else if (busy) wait_cnt <= resp_i ? '0 : wait_cnt + 8'd1;
`else
  assign stall = 1'b0;
  assign timeout_o = 1'b0;
`endif
  // next state: write wins over read in IDLE, DONE always lasts one cycle
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = write_i ? WRITE : read_i ? READ : IDLE;
    else if (state == DONE) state_nx = IDLE;
    else if (last || stall) state_nx = DONE;
  end
  // state, registered handshakes, address/line capture and beat assembly
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      address_o <= '0;
      wr_line   <= '0;
      line_o    <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      state   <= state_nx;
      read_o  <= state_nx == READ;
      write_o <= state_nx == WRITE;
      resp_o  <= state_nx == DONE;
      if (accept) begin
        address_o <= address_i & ~32'h1f;
        beat      <= '0;
        if (write_i) wr_line <= line_i;
      end else if (busy && resp_i) begin
        beat <= beat + KW'(1);
        if (state == READ) line_o[beat*BURST_BITS +: BURST_BITS] <= burst_i;
      end
    end
endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: directed stimulus checked against a transaction-level model of the adaptor
module tb_line_burst_adaptor;
  logic clk, rst, read_i, write_i, resp_i, resp_o, read_o, write_o, timeout_o;
  logic [31:0] address_i, address_o;
  logic [255:0] line_i, line_o;
  logic [63:0] burst_i, burst_o;
  int n_cmp = 0, n_err = 0;

  line_burst_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_i(burst_i), .burst_o(burst_o),
    .resp_i(resp_i), .timeout_o(timeout_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_of(input logic [255:0] l, input int k);
    return l[k*64 +: 64];
  endfunction

  // transaction model: phase 0 idle, 1 reading, 2 writing, 3 done
  int m_phase, m_acks, m_stall;
  logic m_to, m_lx;
  logic [31:0] m_addr;
  logic [255:0] m_wline, m_rline;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_phase <= 0; m_acks <= 0; m_stall <= 0; m_to <= 0; m_lx <= 0;
      m_addr <= '0; m_wline <= '0; m_rline <= '0;
    end else if (m_phase == 0) begin
      if (write_i || read_i) begin
        m_phase <= write_i ? 2 : 1;
        m_addr <= address_i & 32'hFFFF_FFE0;
        m_acks <= 0; m_stall <= 0; m_to <= 0;
        if (write_i) m_wline <= line_i;
        else m_lx <= 0;
      end
    end else if (m_phase == 3) m_phase <= 0;
    else if (resp_i) begin
      if (m_phase == 1) m_rline[m_acks*64 +: 64] <= burst_i;
      m_acks <= m_acks + 1;
      m_stall <= 0;
      if (m_acks == 3) m_phase <= 3;
    end else begin
      m_stall <= m_stall + 1;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
      if (m_stall == 254) begin
        m_phase <= 3; m_to <= 1;
        if (m_phase == 1) m_lx <= 1;
      end
`endif
    end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk)
    if (rst) begin
      check("read_o", read_o, m_phase == 1);
      check("write_o", write_o, m_phase == 2);
      check("resp_o", resp_o, m_phase == 3);
      check("timeout_o", timeout_o, m_phase == 3 && m_to);
      check("address_o", address_o, m_addr);
      check("burst_o", burst_o, m_phase == 2 ? beat_of(m_wline, m_acks) : 64'h0);
      if ((m_phase == 0 || m_phase == 3) && !m_lx) check("line_o", line_o, m_rline);
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] wexp [4];
  bit gap [6];
  int acks, cyc;

  initial begin
    rst = 0; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;
    tick; tick;
    check("rst_read_o", read_o, 0);
    check("rst_write_o", write_o, 0);
    check("rst_resp_o", resp_o, 0);
    check("rst_timeout_o", timeout_o, 0);
    check("rst_address_o", address_o, 0);
    check("rst_line_o", line_o, 0);
    check("rst_burst_o", burst_o, 0);
    rst = 1;
    // resp_i in IDLE is ignored
    resp_i = 1; burst_i = 64'hDEAD; tick; tick;
    resp_i = 0;
    // basic read, ack every cycle
    address_i = 32'h1234_5678; read_i = 1;
    tick;
    check("rd_read_o", read_o, 1);
    check("rd_addr", address_o, 32'h1234_5660);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = 64'h0A + 64'(k);
      tick;
    end
    check("rd_resp_cycle5", resp_o, 1);
    check("rd_line", line_o, {64'h0D, 64'h0C, 64'h0B, 64'h0A});
    check("rd_addr_done", address_o, 32'h1234_5660);
    read_i = 0;
    tick;
    check("rd_resp_one_cycle", resp_o, 0);
    resp_i = 0;
    // gapped write-back
    line_i = {{16{4'hF}}, {16{4'hE}}, {16{4'hD}}, {16{4'hC}}};
    wexp = '{{16{4'hC}}, {16{4'hD}}, {16{4'hE}}, {16{4'hF}}};
    gap = '{1, 0, 1, 1, 0, 1};
    address_i = 32'h0000_0ABF; write_i = 1;
    tick;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      resp_i = gap[i]; burst_i = 64'h5555;
      if (gap[i]) begin
        check("wr_beat", burst_o, wexp[acks]);
        acks++;
      end
      tick;
    end
    check("wr_resp", resp_o, 1);
    check("wr_no_extra_beat", write_o, 0);
    check("wr_addr", address_o, 32'h0000_0AA0);
    write_i = 0; resp_i = 0;
    tick;
    // read and write together: write wins
    address_i = 32'hABCD_0000; line_i = {4{64'h0123_4567_89AB_CDEF}};
    read_i = 1; write_i = 1;
    tick;
    check("prio_write_o", write_o, 1);
    check("prio_read_o", read_o, 0);
    for (int k = 0; k < 4; k++) begin resp_i = 1; tick; end
    read_i = 0; write_i = 0;
    tick;
    resp_i = 0;
    // reset in the middle of a read
    address_i = 32'h0000_1040; read_i = 1;
    tick;
    resp_i = 1; burst_i = 64'h11; tick;
    burst_i = 64'h22; tick;
    rst = 0; read_i = 0; resp_i = 0;
    #1;
    check("abort_read_o", read_o, 0);
    check("abort_line_o", line_o, 0);
    tick;
    rst = 1;
    tick;
    address_i = 32'h0000_2000; read_i = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = 64'h31 + 64'(k);
      tick;
    end
    check("re_resp", resp_o, 1);
    check("re_line", line_o, {64'h34, 64'h33, 64'h32, 64'h31});
    read_i = 0;
    // resp_i held through DONE and IDLE must not advance a later burst
    tick; tick;
    resp_i = 0;
    // stalled read
    address_i = 32'h0000_0300; read_i = 1;
    tick;
    cyc = 1;
    for (int i = 0; i < 300 && !resp_o; i++) begin tick; cyc++; end
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    check("to_cycle", cyc, 256);
    check("to_flag", timeout_o, 1);
    check("to_resp", resp_o, 1);
    read_i = 0;
    tick;
    check("to_flag_pulse", timeout_o, 0);
`else
    check("stall_no_resp", resp_o, 0);
    check("stall_read_o", read_o, 1);
    check("stall_cycles", cyc, 301);
    rst = 0; read_i = 0;
    tick;
    rst = 1;
`endif
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter LINE_BITS, default 256, cache line width.
REQ-002 SHALL have parameter BURST_BITS, default 64, memory beat width; BEATS = LINE_BITS/BURST_BITS (default 4).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port address_i  input  32  cache-side line address.
REQ-007 SHALL have port read_i  input  1  cache line read request, held until resp_o.
REQ-008 SHALL have port write_i  input  1  cache line write-back request, held until resp_o.
REQ-009 SHALL have port line_i  input  LINE_BITS  write-back line data.
REQ-010 SHALL have port line_o  output  LINE_BITS  assembled read line.
REQ-011 SHALL have port resp_o  output  1  one-cycle completion pulse to cache.
REQ-012 SHALL have port address_o  output  32  memory burst address.
REQ-013 SHALL have port read_o / write_o  output  1 each  memory burst request.
REQ-014 SHALL have port burst_i  input  BURST_BITS  memory read beat.
REQ-015 SHALL have port burst_o  output  BURST_BITS  memory write beat.
REQ-016 SHALL have port resp_i  input  1  memory beat acknowledge, one per beat.
REQ-017 SHALL have port timeout_o  output  1  burst-abort pulse (see Configuration).

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-019 In IDLE, write_i=1 SHALL accept a write (priority over read_i); otherwise read_i=1 SHALL accept a read; accept latches {address_i[31:5],5'b0} into address_o, latches line_i for writes, clears beat counter, next state WRITE/READ.
REQ-020 read_o SHALL be 1 exactly while in READ; write_o exactly while in WRITE; both registered outputs.
REQ-021 In READ, each cycle with resp_i=1 SHALL store burst_i into line bits [64k+63:64k], k = beat counter, then increment k.
REQ-022 In WRITE, burst_o SHALL equal latched line bits [64k+63:64k]; k increments on each resp_i=1.
REQ-023 On the resp_i of beat BEATS-1, SHALL go to DONE next cycle; read_o/write_o low in DONE.
REQ-024 In DONE, resp_o SHALL be 1 for exactly one cycle, then IDLE; read_i/write_i SHALL be ignored in DONE.
REQ-025 line_o SHALL be valid when resp_o=1 after a read and hold until the next read is accepted.
REQ-026 resp_i SHALL be ignored in IDLE and DONE; burst_o SHALL be 0 outside WRITE.
REQ-027 Minimum latency: accept at cycle 0, resp_i every cycle -> resp_o at cycle BEATS+1 (5 by default).
REQ-028 address_o SHALL remain constant from accept through DONE.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, beat counter 0, read_o=0, write_o=0, resp_o=0, timeout_o=0, address_o=0, line_o=0, burst_o=0, regardless of state; in-flight burst discarded.

Configuration
REQ-030 With macro LINE_ADAPTOR_TIMEOUT_EN defined, an 8-bit counter SHALL count consecutive READ/WRITE cycles without resp_i, clearing on each resp_i and on accept; on reaching 255, SHALL go to DONE with timeout_o=1 and resp_o=1 in the same cycle; line_o undefined after a timed-out read.
REQ-031 Without LINE_ADAPTOR_TIMEOUT_EN, timeout_o SHALL be tied 0, no counter exists, and bursts wait indefinitely.

Verification
REQ-032 Read: address_i=0x1234_5678, read_i=1, resp_i high 4 cycles with burst_i=0x0..0A,0B,0C,0D -> address_o=0x1234_5660, resp_o at cycle 5, line_o={0D,0C,0B,0A} beats high-to-low.
REQ-033 Write: line_i=0xFF..FF_EE..EE_DD..DD_CC..CC, write_i=1, resp_i gapped (1,0,1,1,0,1) -> burst_o CC..,DD..,EE..,FF.. on acked cycles, resp_o after 4th ack, no extra beats.
REQ-034 Simultaneous read_i=1 and write_i=1 in IDLE -> write_o=1, read_o=0.
REQ-035 rst=0 asserted after 2 read beats -> read_o=0 same cycle, IDLE; subsequent read completes in 5 cycles with correct line_o.
REQ-036 With LINE_ADAPTOR_TIMEOUT_EN, read_i=1 and resp_i held 0 -> timeout_o=1 and resp_o=1 together 256 cycles after accept; without macro, read_o stays 1 and resp_o never asserts.
